// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and constants for the RV32I ID/EX control stage.
// Holds the immediate-type and memory-mode enums, opcode/funct constants,
// the packed control bundle ctrl_t and a source/destination match helper.
package rv32i_ctrl_pkg;

   localparam int unsigned InstW     = 32;
   localparam int unsigned RegAddrW  = 5;
   localparam int unsigned ImmSelW   = 3;
   localparam int unsigned MemModeW  = 2;

   typedef enum logic [ImmSelW-1:0] {
      ImmNop = 3'd0,
      ImmI   = 3'd1,
      ImmS   = 3'd2,
      ImmB   = 3'd3,
      ImmU   = 3'd4,
      ImmJ   = 3'd5,
      ImmR   = 3'd6
   } imm_type_e;

   typedef enum logic [MemModeW-1:0] {
      MemByte = 2'd0,
      MemHalf = 2'd1,
      MemWord = 2'd2
   } mem_mode_e;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   localparam logic [2:0] F3Sll    = 3'b001;
   localparam logic [2:0] F3Srx    = 3'b101;
   localparam logic [2:0] F3AddSub = 3'b000;

   localparam logic [6:0] F7Base   = 7'b0000000;
   localparam logic [6:0] F7Alt    = 7'b0100000;
   localparam logic [6:0] F7MulDiv = 7'b0000001;

   typedef struct packed {
      imm_type_e             imm_type;
      logic                  dmem_read;
      logic                  dmem_write;
      mem_mode_e             dmem_mode;
      logic                  dmem_unsigned;
      logic                  rf_write;
      logic [RegAddrW-1:0]   rd;
      logic [RegAddrW-1:0]   rs1;
      logic [RegAddrW-1:0]   rs2;
      logic                  alu_src_imm;
      logic                  wb_sel_dmem;
      logic                  branch;
      logic                  jump;
      logic                  jalr;
      logic                  illegal;
      logic                  muldiv;
   } ctrl_t;

   // True when a used, nonzero source register equals rd.
   function automatic logic reads_reg(input logic [RegAddrW-1:0] rs1,
                                      input logic [RegAddrW-1:0] rs2,
                                      input logic                use_rs1,
                                      input logic                use_rs2,
                                      input logic [RegAddrW-1:0] rd);
      logic hit1;
      logic hit2;
      hit1 = use_rs1 && (rs1 != '0) && (rs1 == rd);
      hit2 = use_rs2 && (rs2 != '0) && (rs2 == rd);
      return hit1 || hit2;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational RV32I instruction decoder producing the control bundle.
// Ports: instr_i (instruction), ctrl_o (control bundle),
//        uses_rs1_o / uses_rs2_o (source register actually read).
// Optional: CU_RV32M_EN enables M-extension decode (funct7 0000001 on OP);
// without it that encoding is illegal and muldiv is never set.
module cu_decode
   import rv32i_ctrl_pkg::*;
(
   input  logic [InstW-1:0] instr_i,
   output ctrl_t            ctrl_o,
   output logic             uses_rs1_o,
   output logic             uses_rs2_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       legal;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   always_comb begin
      ctrl_o     = '0;
      uses_rs1_o = 1'b0;
      uses_rs2_o = 1'b0;
      legal      = 1'b1;
      ctrl_o.rd  = instr_i[11:7];
      ctrl_o.rs1 = instr_i[19:15];
      ctrl_o.rs2 = instr_i[24:20];

      case (opcode)
         OpLui: begin
            ctrl_o.imm_type    = ImmU;
            ctrl_o.alu_src_imm = 1'b1;
            ctrl_o.rf_write    = 1'b1;
         end
         OpAuipc: begin
            ctrl_o.imm_type = ImmU;
            ctrl_o.rf_write = 1'b1;
         end
         OpJal: begin
            ctrl_o.imm_type = ImmJ;
            ctrl_o.jump     = 1'b1;
            ctrl_o.rf_write = 1'b1;
         end
         OpJalr: begin
            legal           = (funct3 == 3'b000);
            ctrl_o.imm_type = ImmI;
            ctrl_o.jump     = 1'b1;
            ctrl_o.jalr     = 1'b1;
            ctrl_o.rf_write = 1'b1;
            uses_rs1_o      = 1'b1;
         end
         OpBranch: begin
            legal           = (funct3 != 3'b010) && (funct3 != 3'b011);
            ctrl_o.imm_type = ImmB;
            ctrl_o.branch   = 1'b1;
            uses_rs1_o      = 1'b1;
            uses_rs2_o      = 1'b1;
         end
         OpLoad: begin
            legal                = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            ctrl_o.imm_type      = ImmI;
            ctrl_o.dmem_read     = 1'b1;
            ctrl_o.wb_sel_dmem   = 1'b1;
            ctrl_o.rf_write      = 1'b1;
            ctrl_o.dmem_mode     = mem_mode_e'(funct3[1:0]);
            ctrl_o.dmem_unsigned = funct3[2];
            uses_rs1_o           = 1'b1;
         end
         OpStore: begin
            legal             = funct3 inside {3'b000, 3'b001, 3'b010};
            ctrl_o.imm_type   = ImmS;
            ctrl_o.dmem_write = 1'b1;
            ctrl_o.dmem_mode  = mem_mode_e'(funct3[1:0]);
            uses_rs1_o        = 1'b1;
            uses_rs2_o        = 1'b1;
         end
         OpImm: begin
            // Shift-immediates carry funct7 in the upper immediate bits.
            if (funct3 == F3Sll) begin
               legal = (funct7 == F7Base);
            end else if (funct3 == F3Srx) begin
               legal = (funct7 == F7Base) || (funct7 == F7Alt);
            end
            ctrl_o.imm_type    = ImmI;
            ctrl_o.alu_src_imm = 1'b1;
            ctrl_o.rf_write    = 1'b1;
            uses_rs1_o         = 1'b1;
         end
         OpReg: begin
            ctrl_o.imm_type = ImmR;
            ctrl_o.rf_write = 1'b1;
            uses_rs1_o      = 1'b1;
            uses_rs2_o      = 1'b1;
            if (funct7 == F7Base) begin
               legal = 1'b1;
            end else if (funct7 == F7Alt) begin
               legal = (funct3 == F3AddSub) || (funct3 == F3Srx);
`ifdef CU_RV32M_EN
            end else if (funct7 == F7MulDiv) begin
               ctrl_o.muldiv = 1'b1;
`endif
            end else begin
               legal = 1'b0;
            end
         end
         default: legal = 1'b0;
      endcase

      if (!legal) begin
         ctrl_o         = '0;
         ctrl_o.illegal = 1'b1;
         uses_rs1_o     = 1'b0;
         uses_rs2_o     = 1'b0;
      end else if (ctrl_o.rd == '0) begin
         ctrl_o.rf_write = 1'b0;
      end
   end

endmodule

// File: rtl/cu_pipe_ctrl.sv
// Registered ID/EX control stage: decodes one instruction per cycle and holds
// the control bundle in an output register with valid/ready on both sides.
// Inserts LOAD_USE_BUBBLES bubbles between a load and a dependent instruction,
// supports a synchronous flush and flags illegal encodings.
// Ports: clk, rst_n (async active-low); in_valid_i/in_ready_o/in_instr_i from
// IF/ID; flush_i; out_valid_o/out_ready_i and the out_*_o bundle towards EX.
// Optional: CU_RV32M_EN (decoded in cu_decode) drives out_muldiv_o.
module cu_pipe_ctrl
   import rv32i_ctrl_pkg::*;
#(
   parameter int unsigned INST_WIDTH       = 32,
   parameter int unsigned REG_ADDR_WIDTH   = 5,
   parameter int unsigned IMM_SEL_WIDTH    = 3,
   parameter int unsigned MEM_MODE_WIDTH   = 2,
   parameter int unsigned LOAD_USE_BUBBLES = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [INST_WIDTH-1:0]     in_instr_i,
   input  logic                      flush_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [IMM_SEL_WIDTH-1:0]  out_imm_type_o,
   output logic                      out_dmem_read_o,
   output logic                      out_dmem_write_o,
   output logic [MEM_MODE_WIDTH-1:0] out_dmem_mode_o,
   output logic                      out_dmem_unsigned_o,
   output logic                      out_rf_write_o,
   output logic [REG_ADDR_WIDTH-1:0] out_rd_o,
   output logic [REG_ADDR_WIDTH-1:0] out_rs1_o,
   output logic [REG_ADDR_WIDTH-1:0] out_rs2_o,
   output logic                      out_alu_src_imm_o,
   output logic                      out_wb_sel_dmem_o,
   output logic                      out_branch_o,
   output logic                      out_jump_o,
   output logic                      out_jalr_o,
   output logic                      out_illegal_o,
   output logic                      out_muldiv_o
);

   localparam int unsigned CntW = (LOAD_USE_BUBBLES > 1) ? $clog2(LOAD_USE_BUBBLES) : 1;

   ctrl_t               dec;
   logic                use_rs1;
   logic                use_rs2;

   ctrl_t               ctrl_q, ctrl_d;
   logic                valid_q, valid_d;
   logic [CntW-1:0]     hz_cnt_q, hz_cnt_d;
   logic [RegAddrW-1:0] hz_rd_q, hz_rd_d;

   logic stall_a;
   logic stall_b;
   logic load_en;
   logic accept;
   logic depart;

   cu_decode u_decode (
      .instr_i    (in_instr_i),
      .ctrl_o     (dec),
      .uses_rs1_o (use_rs1),
      .uses_rs2_o (use_rs2)
   );

   // Held load whose rd feeds the incoming instruction.
   assign stall_a = valid_q && ctrl_q.dmem_read &&
                    reads_reg(dec.rs1, dec.rs2, use_rs1, use_rs2, ctrl_q.rd);
   // Load already gone to EX but its data is still LOAD_USE_BUBBLES away.
   assign stall_b = (hz_cnt_q != '0) &&
                    reads_reg(dec.rs1, dec.rs2, use_rs1, use_rs2, hz_rd_q);

   assign load_en    = !valid_q || out_ready_i;
   assign in_ready_o = !flush_i && !stall_a && !stall_b && load_en;
   assign accept     = in_valid_i && in_ready_o;
   // A flushed bundle never counts as departed, even if EX was ready.
   assign depart     = valid_q && out_ready_i && !flush_i;

   always_comb begin
      valid_d  = valid_q;
      ctrl_d   = ctrl_q;
      hz_cnt_d = hz_cnt_q;
      hz_rd_d  = hz_rd_q;

      if (hz_cnt_q != '0) begin
         hz_cnt_d = hz_cnt_q - 1'b1;
      end
      if (depart && ctrl_q.dmem_read && (ctrl_q.rd != '0)) begin
         hz_rd_d  = ctrl_q.rd;
         hz_cnt_d = CntW'(LOAD_USE_BUBBLES - 1);
      end
      if (load_en) begin
         valid_d = accept;
         ctrl_d  = accept ? dec : '0;
      end
      if (flush_i) begin
         valid_d  = 1'b0;
         ctrl_d   = '0;
         hz_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         ctrl_q   <= '0;
         hz_cnt_q <= '0;
         hz_rd_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         ctrl_q   <= ctrl_d;
         hz_cnt_q <= hz_cnt_d;
         hz_rd_q  <= hz_rd_d;
      end
   end

   assign out_valid_o         = valid_q;
   assign out_imm_type_o      = ctrl_q.imm_type;
   assign out_dmem_read_o     = ctrl_q.dmem_read;
   assign out_dmem_write_o    = ctrl_q.dmem_write;
   assign out_dmem_mode_o     = ctrl_q.dmem_mode;
   assign out_dmem_unsigned_o = ctrl_q.dmem_unsigned;
   assign out_rf_write_o      = ctrl_q.rf_write;
   assign out_rd_o            = ctrl_q.rd;
   assign out_rs1_o           = ctrl_q.rs1;
   assign out_rs2_o           = ctrl_q.rs2;
   assign out_alu_src_imm_o   = ctrl_q.alu_src_imm;
   assign out_wb_sel_dmem_o   = ctrl_q.wb_sel_dmem;
   assign out_branch_o        = ctrl_q.branch;
   assign out_jump_o          = ctrl_q.jump;
   assign out_jalr_o          = ctrl_q.jalr;
   assign out_illegal_o       = ctrl_q.illegal;
   assign out_muldiv_o        = ctrl_q.muldiv;

endmodule

// File: doc/cu_pipe_ctrl.md
Name: cu_pipe_ctrl

Overview:
- Registered ID/EX control stage for the RV32I pipeline: decodes one instruction per cycle into the control bundle and holds it in an output register.
- Adds a valid/ready handshake on both sides, load-use hazard stalling with a configurable bubble count, synchronous flush, illegal-instruction flagging and forced x0 write suppression.
- Sits between the IF/ID register and the EX stage, replacing the purely combinational control path.

Parameters:
- INST_WIDTH, 32, instruction width.
- REG_ADDR_WIDTH, 5, register index width.
- IMM_SEL_WIDTH, 3, immediate-type select width.
- MEM_MODE_WIDTH, 2, DMEM access-size width.
- LOAD_USE_BUBBLES, 1, bubbles inserted between a load and a dependent instruction (>=1; models DMEM latency).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  INST_WIDTH  instruction from IF/ID.
- flush  in  1  kill the held instruction and the hazard state (branch/jump resolved in EX).
- out_valid  out  1  control bundle is valid.
- out_ready  in  1  EX consumes the bundle.
- out_imm_type  out  IMM_SEL_WIDTH  immediate generator select.
- out_dmem_read, out_dmem_write  out  1 each  DMEM enables.
- out_dmem_mode  out  MEM_MODE_WIDTH  byte/half/word.
- out_dmem_unsigned  out  1  LBU/LHU zero-extend.
- out_rf_write  out  1  RF write enable.
- out_rd, out_rs1, out_rs2  out  REG_ADDR_WIDTH each  register indices.
- out_alu_src_imm  out  1  ALU operand b = immediate.
- out_wb_sel_dmem  out  1  WB takes DMEM data.
- out_branch, out_jump, out_jalr  out  1 each  control-flow class.
- out_illegal  out  1  undecodable instruction.
- out_muldiv  out  1  M-extension op (0 when the feature is off).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, every out_* = 0 (imm type NOP=0, mode BYTE=0), hazard counter=0, hazard rd=0.
- Latency: 1 cycle from accept (in_valid&&in_ready) to out_valid=1.
- Output register loads when (!out_valid || out_ready). Otherwise it holds and all outputs stay stable.
- in_ready = !flush && !stall && (!out_valid || out_ready).
- If the register is free and no accept occurs, out_valid becomes 0 (bubble).
- uses_rs1: every type except U and J. uses_rs2: R-type registers, S and B only (not the shift-immediates).
- A source matches when it is used, nonzero and equal to the load's rd.
- Stall term A: out_valid and the held bundle is a load with rd matching the incoming instruction.
- Stall term B: hz_cnt != 0 and hz_rd matches the incoming instruction.
- On departure of a load with rd != 0: hz_rd <= rd, hz_cnt <= LOAD_USE_BUBBLES-1. hz_cnt decrements to 0 each cycle.
- Result: exactly LOAD_USE_BUBBLES bubbles when EX is always ready.
- Flush: has priority. Next cycle out_valid=0, hz_cnt=0. No accept in the flush cycle. Simultaneous flush and out_ready drops the held bundle.
- Illegal: unknown opcode/funct3/funct7 (including SLLI with funct7 != 0). Sets out_valid=1, out_illegal=1, all enables and branch/jump=0, imm NOP.
- rd == 0: out_rf_write forced 0 and the instruction is never treated as a load hazard source.
- Enables per class: loads set dmem_read, wb_sel_dmem and rf_write; stores set dmem_write; ALU-imm/LUI set alu_src_imm and rf_write; JAL/JALR/AUIPC set rf_write.

Optional Feature:
- CU_RV32M_EN defined: opcode 0110011 with funct7 0000001 decodes as R-type, out_muldiv=1, rf_write=1, legal.
- CU_RV32M_EN undefined: the same encoding sets out_illegal=1, and out_muldiv is tied 0.

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - imm_type enum: NOP=0, I=1, S=2, B=3, U=4, J=5, R=6.
  - mem_mode enum: BYTE=0, HALF=1, WORD=2.
  - Opcode/funct3/funct7 constants.
  - A packed ctrl_t struct for the bundle.
- Sub-module cu_decode: purely combinational in_instr -> ctrl_t plus uses_rs1/uses_rs2. cu_pipe_ctrl owns the handshake, register, hazard counter and flush.

Test Plan:
- ADDI x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, imm=I, alu_src_imm=1, rf_write=1, rd=1.
- LW x2,0(x1) (0x0000A103) then ADD x3,x2,x1 (0x001101B3), LOAD_USE_BUBBLES=1 -> exactly one out_valid=0 cycle between them. Repeat with LOAD_USE_BUBBLES=3 -> three bubbles.
- LW x0,0(x1) followed by ADD x3,x0,x1 -> no bubble, and the LW bundle has rf_write=0.
- out_ready=0 for 4 cycles with ADD held -> outputs stable and in_ready=0. Then out_ready=1 -> ADD consumed, next instruction accepted the same cycle.
- flush asserted while LW is held and its dependent is waiting -> next cycle out_valid=0, hz_cnt=0. Dependent accepted the cycle after without a bubble.
- MUL x3,x1,x2 (0x022081B3) -> with CU_RV32M_EN: out_muldiv=1, out_illegal=0. Without it: out_illegal=1, rf_write=0. 0xFFFFFFFF -> out_illegal=1 in both builds.
